// File: rtl/fft_frame_ctrl_if.sv
// fft_frame_ctrl_if: sample-in / bin-out valid-ready streams of the FFT frame controller
interface fft_frame_ctrl_if #(parameter int WIDTH = 32) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  modport master (output in_valid, in_data, in_last, out_ready,
                  input  in_ready, out_valid, out_data, out_last);
  modport slave  (input  in_valid, in_data, in_last, out_ready,
                  output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: collects an N-sample frame, holds it on the FFT inputs, captures and streams the N bins
module fft_frame_ctrl #(
  parameter int N           = 8,
  parameter int WIDTH       = 32,
  parameter int FFT_LATENCY = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_frame_ctrl_if.slave    io,
  output logic [N*WIDTH-1:0] fft_in,
  input  logic [N*WIDTH-1:0] fft_out,
  output logic               busy,
  output logic               frame_err,
  output logic [15:0]        frames_done
);
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
  state_t           state;
  logic [IW-1:0]    idx;
  logic [7:0]       wcnt;
  logic [WIDTH-1:0] samp [N];
  logic [WIDTH-1:0] res  [N];
  logic             out_valid;
  logic             out_last;
  logic             last_idx;
  assign last_idx     = idx == IW'(N - 1);
  assign io.in_ready  = state == LOAD;
  assign io.out_valid = out_valid;
  assign io.out_last  = out_last;
  assign io.out_data  = res[idx];
  // sample 0 sits at the MSBs of the packed bus
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign fft_in[(N-g)*WIDTH-1 -: WIDTH] = samp[g];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      idx         <= '0;
      wcnt        <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
      frames_done <= '0;
      for (int k = 0; k < N; k++) begin
        samp[k] <= '0;
        res[k]  <= '0;
      end
    end else begin
      frame_err <= 1'b0;
      case (state)
        LOAD: if (io.in_valid) begin
          samp[idx] <= io.in_data;
          if (last_idx) begin
            idx       <= '0;
            state     <= COMPUTE;
            busy      <= 1'b1;
            wcnt      <= 8'(FFT_LATENCY);
            frame_err <= !io.in_last;
          end else if (io.in_last) begin
            idx       <= '0;
            frame_err <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        COMPUTE: if (wcnt == 8'd0) begin
          for (int k = 0; k < N; k++) res[k] <= fft_out[(N-k)*WIDTH-1 -: WIDTH];
          state     <= UNLOAD;
          out_valid <= 1'b1;
          out_last  <= 1'b0;
        end else begin
          wcnt <= wcnt - 8'd1;
        end
        UNLOAD: if (io.out_ready) begin
          if (last_idx) begin
            state       <= LOAD;
            idx         <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            frames_done <= frames_done + 16'd1;
          end else begin
            idx      <= idx + 1'b1;
            out_last <= idx == IW'(N - 2);
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed scoreboard bench with stub FFTs (latency 0 and latency 3 instances)
module tb_fft_frame_ctrl;
  localparam int N = 8;
  localparam int W = 32;
  localparam logic [W-1:0] XK = 32'hA5A50F0F;
  typedef struct packed {logic [W-1:0] d; logic l;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fft_frame_ctrl_if #(.WIDTH(W)) a ();
  fft_frame_ctrl_if #(.WIDTH(W)) b ();
  logic [N*W-1:0] fin_a, fout_a, fin_b, fout_b;
  logic           busy_a, err_a, busy_b, err_b;
  logic [15:0]    fd_a, fd_b;
  logic [31:0]    cyc = 0;
  int             tests = 0;
  int             fails = 0;
  int             err_cnt = 0;
  exp_t           q[$];
  logic [W-1:0]   fr [N];
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (err_a === 1'b1) err_cnt <= err_cnt + 1;
  // stub A: bin k = sample N-1-k xor a constant; stub B: bin k = {cycle count, k}
  for (genvar k = 0; k < N; k++) begin : g_stub
    assign fout_a[(N-k)*W-1 -: W] = fin_a[(k+1)*W-1 -: W] ^ XK;
    assign fout_b[(N-k)*W-1 -: W] = {cyc[15:0], 16'(k)};
  end
  fft_frame_ctrl #(.N(N), .WIDTH(W), .FFT_LATENCY(0)) u_a (
    .clk(clk), .rst_n(rst_n), .io(a), .fft_in(fin_a), .fft_out(fout_a),
    .busy(busy_a), .frame_err(err_a), .frames_done(fd_a));
  fft_frame_ctrl #(.N(N), .WIDTH(W), .FFT_LATENCY(3)) u_b (
    .clk(clk), .rst_n(rst_n), .io(b), .fft_in(fin_b), .fft_out(fout_b),
    .busy(busy_b), .frame_err(err_b), .frames_done(fd_b));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input int n, input int last_at);
    chk("in_ready_load", a.in_ready, 1);
    for (int i = 0; i < n; i++) begin
      a.in_valid = 1'b1;
      a.in_data  = fr[i];
      a.in_last  = (i == last_at);
      @(negedge clk);
    end
    a.in_valid = 1'b0;
    a.in_last  = 1'b0;
    a.in_data  = '0;
    if (n == N) for (int k = 0; k < N; k++) q.push_back('{d: fr[N-1-k] ^ XK, l: k == N - 1});
  endtask
  task automatic recv(input int pat, input int nb);
    int got = 0;
    int t = 0;
    logic hold = 1'b0;
    logic [W-1:0] pd = '0;
    logic pl = 1'b0;
    exp_t e;
    while (got < nb && t < 300) begin
      chk("busy_unload", busy_a, 1);
      chk("in_ready_busy", a.in_ready, 0);
      if (hold) begin
        chk("hold_data", a.out_data, pd);
        chk("hold_last", a.out_last, pl);
      end
      a.out_ready = (pat == 0) ? 1'b1 : (t % 3 == 0);
      hold = a.out_valid && !a.out_ready;
      pd = a.out_data;
      pl = a.out_last;
      if (a.out_valid && a.out_ready) begin
        chk("sb_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("bin_data", a.out_data, e.d);
          chk("bin_last", a.out_last, e.l);
        end
        got++;
      end
      t++;
      @(negedge clk);
    end
    chk("recv_count", got, nb);
  endtask
  initial begin
    int got, idle, t;
    logic [15:0] cap;
    fr = '{32'h3c000000, 32'h40000000, 32'h42000000, 32'h44000000,
           32'h44000000, 32'h42000000, 32'h40000000, 32'h3c000000};
    {a.in_valid, a.in_last, b.in_valid, b.in_last} = '0;
    a.in_data = '0;
    b.in_data = '0;
    a.out_ready = 1'b1;
    b.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", a.in_ready, 1);
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_out_last", a.out_last, 0);
    chk("rst_out_data", a.out_data, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_frame_err", err_a, 0);
    chk("rst_frames_done", fd_a, 0);
    chk("rst_fft_in", |fin_a, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // 1: nominal frame, sink always ready
    send(N, N - 1);
    chk("t1_pack_s0", fin_a[N*W-1 -: W], fr[0]);
    chk("t1_pack_s7", fin_a[W-1:0], fr[N-1]);
    recv(0, N);
    chk("t1_frames_done", fd_a, 1);
    chk("t1_no_err", err_cnt, 0);
    chk("t1_idle_valid", a.out_valid, 0);
    chk("t1_idle_busy", busy_a, 0);
    // 2: sink stalls 1,0,0 pattern
    send(N, N - 1);
    recv(1, N);
    chk("t2_frames_done", fd_a, 2);
    // 3: early in_last aborts, then a fresh frame
    for (int i = 0; i < N; i++) fr[i] = {16'(i * 257), 16'hbeef};
    send(3, 2);
    chk("t3_err_pulse", err_a, 1);
    chk("t3_stay_load", a.in_ready, 1);
    chk("t3_not_busy", busy_a, 0);
    @(negedge clk);
    chk("t3_err_clear", err_a, 0);
    send(N, N - 1);
    recv(0, N);
    chk("t3_frames_done", fd_a, 3);
    chk("t3_err_count", err_cnt, 1);
    // 4: missing in_last still processes the frame
    send(N, -1);
    chk("t4_err_pulse", err_a, 1);
    chk("t4_in_ready_low", a.in_ready, 0);
    recv(0, N);
    chk("t4_in_ready_back", a.in_ready, 1);
    chk("t4_frames_done", fd_a, 4);
    chk("t4_err_count", err_cnt, 2);
    // 5: latency-3 instance captures 4 cycles after the last accept
    cap = '0;
    for (int i = 0; i < N; i++) begin
      b.in_valid = 1'b1;
      b.in_data  = fr[i];
      b.in_last  = (i == N - 1);
      if (i == N - 1) cap = 16'(cyc + 4);
      @(negedge clk);
    end
    b.in_valid = 1'b0;
    b.in_last  = 1'b0;
    got = 0;
    idle = 0;
    t = 0;
    while (got < N && t < 100) begin
      chk("t5_busy", busy_b, 1);
      chk("t5_in_ready", b.in_ready, 0);
      if (b.out_valid) begin
        chk("t5_bin_data", b.out_data, {cap, 16'(got)});
        chk("t5_bin_last", b.out_last, got == N - 1);
        got++;
      end else if (got == 0) idle++;
      t++;
      @(negedge clk);
    end
    chk("t5_compute_cycles", idle, 4);
    chk("t5_count", got, N);
    chk("t5_frames_done", fd_b, 1);
    chk("t5_idle_busy", busy_b, 0);
    // 6: async reset while bin 5 is on the output
    send(N, N - 1);
    recv(0, 5);
    a.out_ready = 1'b0;
    chk("t6_bin5_shown", a.out_data, q[0].d);
    chk("t6_valid_before", a.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", a.out_valid, 0);
    chk("t6_rst_busy", busy_a, 0);
    chk("t6_rst_frames_done", fd_a, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    a.out_ready = 1'b1;
    chk("t6_in_ready", a.in_ready, 1);
    @(negedge clk);
    send(N, N - 1);
    recv(0, N);
    chk("t6_frames_done", fd_a, 1);
    chk("t6_sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
